// File: rtl/btt_pkg.sv
// btt_pkg: shared types for the branch-target table
package btt_pkg;
  localparam int ENTRY_D = 8;
  typedef enum logic {CLEAR, READY} state_t;
  typedef struct packed {
    logic valid;
    logic abs;
    logic [ENTRY_D-1:0] target;
  } entry_t;
endpackage

// File: rtl/btt_entry_ram.sv
// btt_entry_ram: target storage with one write port, async read and per-entry valid clear
module btt_entry_ram #(
  parameter int D = 8,
  parameter int AW = 5,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [D-1:0]  wtarget,
  input  logic          wabs,
  input  logic          clr,
  input  logic [AW-1:0] caddr,
  input  logic [AW-1:0] raddr,
  output logic          rvalid,
  output logic          rabs,
  output logic [D-1:0]  rtarget
);
  logic [DEPTH-1:0] valid;
  logic [D:0] mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= '0;
    else if (we) valid[waddr] <= 1'b1;
    else if (clr) valid[caddr] <= 1'b0;
  // payload needs no reset: it is only trusted behind its valid bit
  always_ff @(posedge clk)
    if (we) mem[waddr] <= {wabs, wtarget};
  assign rvalid = valid[raddr];
  assign {rabs, rtarget} = mem[raddr];
endmodule

// File: rtl/branch_target_table.sv
// branch_target_table: programmable branch-target table returning a registered resolved next PC
module branch_target_table
  import btt_pkg::*;
#(
  parameter int D = 8,
  parameter int AW = 5,
  parameter int DEPTH = 2**AW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          flush,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [D-1:0]  wr_target,
  input  logic          wr_abs,
  input  logic          lk_valid,
  output logic          lk_ready,
  input  logic [AW-1:0] lk_addr,
  input  logic [D-1:0]  lk_pc,
  input  logic          lk_taken,
  output logic          nxt_valid,
  output logic [D-1:0]  nxt_pc,
  output logic          nxt_miss
);
  state_t state, state_n;
  logic [AW-1:0] clr_idx;
  logic rd_valid, rd_abs, lk_fire, miss_res;
  logic [D-1:0] rd_target, pc_res;
  assign wr_ready = state == READY;
  assign lk_ready = state == READY;
  assign lk_fire = lk_valid & lk_ready;
  btt_entry_ram #(.D(D), .AW(AW), .DEPTH(DEPTH)) u_ram (
    .clk(Clk), .rst(Reset),
    .we(wr_valid & wr_ready), .waddr(wr_addr), .wtarget(wr_target), .wabs(wr_abs),
    .clr(state == CLEAR), .caddr(clr_idx),
    .raddr(lk_addr), .rvalid(rd_valid), .rabs(rd_abs), .rtarget(rd_target)
  );
  always_comb begin
    state_n = state;
    if (state == CLEAR) state_n = clr_idx == AW'(DEPTH-1) ? READY : CLEAR;
    else state_n = flush ? CLEAR : READY;
  end
  // relative add is the same bit pattern whether target is read as signed or not
  always_comb begin
    pc_res = !lk_taken ? lk_pc + D'(1) : !rd_valid ? lk_pc : rd_abs ? rd_target : lk_pc + rd_target;
    miss_res = lk_taken & ~rd_valid;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= CLEAR;
      clr_idx <= '0;
      nxt_valid <= 1'b0;
      nxt_pc <= '0;
      nxt_miss <= 1'b0;
    end else begin
      state <= state_n;
      clr_idx <= state == CLEAR ? clr_idx + AW'(1) : '0;
      nxt_valid <= lk_fire;
      if (lk_fire) begin
        nxt_pc <= pc_res;
        nxt_miss <= miss_res;
      end
    end
endmodule

// File: tb/tb_branch_target_table.sv
// tb_branch_target_table: directed vector bench for branch_target_table
module tb_branch_target_table;
  logic Clk = 0, Reset = 1, flush = 0;
  logic wr_valid = 0, wr_abs = 0, lk_valid = 0, lk_taken = 0;
  logic [4:0] wr_addr = 0, lk_addr = 0;
  logic [7:0] wr_target = 0, lk_pc = 0;
  logic wr_ready, lk_ready, nxt_valid, nxt_miss;
  logic [7:0] nxt_pc;
  int tests = 0, failed = 0, n;

  typedef struct {
    bit         wr;
    logic [4:0] addr;
    logic [7:0] val;
    logic       ab;
    logic [7:0] pc;
    logic       tk;
    logic [7:0] epc;
    logic       emiss;
  } vec_t;
  vec_t v[15];

  branch_target_table dut (
    .Clk(Clk), .Reset(Reset), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_target(wr_target), .wr_abs(wr_abs),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_addr(lk_addr), .lk_pc(lk_pc), .lk_taken(lk_taken),
    .nxt_valid(nxt_valid), .nxt_pc(nxt_pc), .nxt_miss(nxt_miss)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_wr(input logic [4:0] a, input logic [7:0] t, input logic ab);
    wr_addr = a; wr_target = t; wr_abs = ab; wr_valid = 1;
    check("wr_ready", wr_ready, 1);
    @(posedge Clk); #1;
    wr_valid = 0;
  endtask

  task automatic do_lk(input logic [4:0] a, input logic [7:0] pc, input logic tk);
    lk_addr = a; lk_pc = pc; lk_taken = tk; lk_valid = 1;
    @(posedge Clk); #1;
    lk_valid = 0;
  endtask

  task automatic chk_res(input string name, input int epc, input int emiss);
    check({name, " valid"}, nxt_valid, 1);
    check({name, " pc"}, nxt_pc, epc);
    check({name, " miss"}, nxt_miss, emiss);
  endtask

  task automatic wait_ready(input string name);
    n = 0;
    while (!lk_ready && n < 40) begin
      @(posedge Clk); #1;
      n++;
      if (wr_ready) check({name, " wr_ready"}, wr_ready, lk_ready);
    end
    check({name, " sweep cycles"}, n, 32);
  endtask

  initial begin
    v[0]  = '{0, 5'd3,  8'd0,   0, 8'd10,  1, 8'd10,  1};
    v[1]  = '{0, 5'd3,  8'd0,   0, 8'd10,  0, 8'd11,  0};
    v[2]  = '{1, 5'd5,  8'hF9,  0, 8'd0,   0, 8'd0,   0};
    v[3]  = '{0, 5'd5,  8'd0,   0, 8'd20,  1, 8'd13,  0};
    v[4]  = '{0, 5'd5,  8'd0,   0, 8'd20,  0, 8'd21,  0};
    v[5]  = '{1, 5'd0,  8'd134, 1, 8'd0,   0, 8'd0,   0};
    v[6]  = '{0, 5'd0,  8'd0,   0, 8'd200, 1, 8'd134, 0};
    v[7]  = '{1, 5'd0,  8'd6,   0, 8'd0,   0, 8'd0,   0};
    v[8]  = '{0, 5'd0,  8'd0,   0, 8'd200, 1, 8'd206, 0};
    v[9]  = '{1, 5'd7,  8'd95,  0, 8'd0,   0, 8'd0,   0};
    v[10] = '{0, 5'd7,  8'd0,   0, 8'd200, 1, 8'd39,  0};
    v[11] = '{0, 5'd7,  8'd0,   0, 8'd255, 0, 8'd0,   0};
    v[12] = '{0, 5'd9,  8'd0,   0, 8'd255, 1, 8'd255, 1};
    v[13] = '{1, 5'd31, 8'd16,  1, 8'd0,   0, 8'd0,   0};
    v[14] = '{0, 5'd31, 8'd0,   0, 8'd0,   1, 8'd16,  0};

    @(posedge Clk); #1;
    check("rst nxt_valid", nxt_valid, 0);
    check("rst nxt_pc", nxt_pc, 0);
    check("rst nxt_miss", nxt_miss, 0);
    check("rst lk_ready", lk_ready, 0);
    check("rst wr_ready", wr_ready, 0);

    lk_valid = 1; lk_addr = 3; lk_pc = 10; lk_taken = 1;
    Reset = 0;
    wait_ready("init");
    check("init no result", nxt_valid, 0);
    lk_valid = 0;

    foreach (v[i]) begin
      if (v[i].wr) do_wr(v[i].addr, v[i].val, v[i].ab);
      else begin
        do_lk(v[i].addr, v[i].pc, v[i].tk);
        chk_res($sformatf("vec%0d", i), v[i].epc, v[i].emiss);
      end
    end

    // same-cycle write and lookup, then a back-to-back lookup
    wr_addr = 2; wr_target = 50; wr_abs = 1; wr_valid = 1;
    lk_addr = 2; lk_pc = 7; lk_taken = 1; lk_valid = 1;
    @(posedge Clk); #1;
    wr_valid = 0;
    chk_res("rbw", 7, 1);
    @(posedge Clk); #1;
    lk_valid = 0;
    chk_res("after wr", 50, 0);
    @(posedge Clk); #1;
    check("strobe drop", nxt_valid, 0);

    // flush with a concurrent lookup, writes during sweep ignored
    for (int i = 0; i < 4; i++) do_wr(5'(i), 8'(100 + i), 1);
    flush = 1; lk_addr = 1; lk_pc = 0; lk_taken = 1; lk_valid = 1;
    @(posedge Clk); #1;
    flush = 0; lk_valid = 0;
    chk_res("flush lk", 101, 0);
    check("flush lk_ready", lk_ready, 0);
    check("flush wr_ready", wr_ready, 0);
    wr_addr = 0; wr_target = 77; wr_abs = 1; wr_valid = 1;
    wait_ready("flush");
    wr_valid = 0;
    for (int i = 0; i < 4; i++) begin
      do_lk(5'(i), 8'(40 + i), 1);
      chk_res($sformatf("cleared%0d", i), 40 + i, 1);
    end

    // reset mid-sweep drops held result and restarts the sweep
    do_lk(5'd4, 8'd60, 0);
    chk_res("pre-rst", 61, 0);
    flush = 1;
    @(posedge Clk); #1;
    flush = 0;
    repeat (10) @(posedge Clk);
    #2 Reset = 1;
    #1;
    check("midrst nxt_pc", nxt_pc, 0);
    check("midrst nxt_miss", nxt_miss, 0);
    check("midrst nxt_valid", nxt_valid, 0);
    check("midrst lk_ready", lk_ready, 0);
    @(posedge Clk); #1;
    Reset = 0;
    wait_ready("restart");
    do_lk(5'd2, 8'd5, 1);
    chk_res("post-rst", 5, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
